// File: rtl/mem_stage_ctrl_if.sv
// ============================================================================
// Module   : mem_stage_ctrl_if
// Brief    : Data-memory req/ack port between the MEM stage and data memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_stage_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// Module   : mem_stage_ctrl
// Brief    : MEM stage: data-memory access FSM, pipeline stall, branch resolve,
//            MEM/WB pipeline register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_stage_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [DATA_W-1:0] branch_addr_i,
    input  wire logic [DATA_W-1:0] alu_result_i,
    input  wire logic [DATA_W-1:0] store_data_i,
    input  wire logic [4:0]        rd_i,
    input  wire logic              zero_i,
    input  wire logic              reg_write_i,
    input  wire logic              mem_to_reg_i,
    input  wire logic              mem_read_i,
    input  wire logic              mem_write_i,
    input  wire logic              branch_i,
    mem_stage_ctrl_if.master       dmem,
    output logic                   stall_o,
    output logic                   pc_src_o,
    output logic [DATA_W-1:0]      pc_target_o,
    output logic [DATA_W-1:0]      wb_read_data_o,
    output logic [DATA_W-1:0]      wb_alu_result_o,
    output logic [4:0]             wb_rd_o,
    output logic                   wb_reg_write_o,
    output logic                   wb_mem_to_reg_o,
    output logic                   mem_err_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              stall;
    logic              access;

    assign access = mem_read_i | mem_write_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    stall = 1'b1;
                    if (alu_result_i[1:0] != 2'b00) begin
                        // Misaligned: never reaches memory, retire with zero data
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = S_DONE;
                    end else begin
                        addr_d  = alu_result_i;
                        wdata_d = store_data_i;
                        we_d    = mem_write_i;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                // Ack is checked first so a response on the last allowed cycle wins
                if (dmem.mem_ack) begin
                    rdata_d = we_q ? '0 : dmem.mem_rdata;
                    req_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_read_data_o  <= '0;
            wb_alu_result_o <= '0;
            wb_rd_o         <= '0;
            wb_reg_write_o  <= 1'b0;
            wb_mem_to_reg_o <= 1'b0;
        end else if (stall) begin
            wb_reg_write_o  <= 1'b0;
            wb_mem_to_reg_o <= 1'b0;
        end else begin
            wb_alu_result_o <= alu_result_i;
            wb_rd_o         <= rd_i;
            wb_reg_write_o  <= reg_write_i;
            wb_mem_to_reg_o <= mem_to_reg_i;
            wb_read_data_o  <= (state_q == S_DONE) ? rdata_q : '0;
        end
    end

    assign stall_o        = stall;
    assign pc_src_o       = branch_i & zero_i & ~stall;
    assign pc_target_o    = branch_addr_i;
    assign mem_err_o      = err_q;
    assign dmem.mem_req   = req_q;
    assign dmem.mem_we    = we_q;
    assign dmem.mem_addr  = addr_q;
    assign dmem.mem_wdata = wdata_q;

endmodule

`default_nettype wire
